// File: rtl/fetch_s_block_pkg.sv
// Shared types and constants for the S-block SRAM fetch path.
package fetch_s_block_pkg;

    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned S_ADDR_W = 7;
    localparam int unsigned S_DATA_W = 32;
    localparam int unsigned RC_W     = 10;
    localparam int unsigned TAG_W    = 5;

    localparam logic [ADDR_W-1:0] Y_BASE_DEF = 18'd0;
    localparam logic [ADDR_W-1:0] U_BASE_DEF = 18'd38400;
    localparam logic [ADDR_W-1:0] V_BASE_DEF = 18'd57600;
    localparam logic [ADDR_W-1:0] Y_WORDS    = 18'd160;
    localparam logic [ADDR_W-1:0] UV_WORDS   = 18'd80;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_t;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_ISSUE = 2'd1;
    localparam fetch_state_t S_DRAIN = 2'd2;
    localparam fetch_state_t S_DONE  = 2'd3;

    // One entry of the read-latency delay line
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } pipe_ent_t;

    // Plane code 3 is reserved and aliases V
    function automatic plane_t decode_plane(input logic [1:0] p);
        case (p)
            2'd0:    return PLANE_Y;
            2'd1:    return PLANE_U;
            default: return PLANE_V;
        endcase
    endfunction

    // x * stride with shifts and adds only (160 = 128+32, 80 = 64+16)
    function automatic logic [ADDR_W-1:0] row_offset(input logic [RC_W-1:0] x, input logic is_y);
        logic [ADDR_W-1:0] xe;
        xe = ADDR_W'(x);
        return is_y ? ((xe << 7) + (xe << 5)) : ((xe << 6) + (xe << 4));
    endfunction

endpackage

// File: rtl/fetch_s_block_if.sv
// Request/done handshake, SRAM read bus and S RAM write ports of the fetch block.
interface fetch_s_block_if;
    import fetch_s_block_pkg::*;

    logic                  start;
    logic [1:0]            plane;
    logic [RC_W-1:0]       RA_init;
    logic [RC_W-1:0]       CA_init;
    logic [ADDR_W-1:0]     SRAM_address;
    logic                  SRAM_we_n;
    logic [DATA_W-1:0]     SRAM_read_data;
    logic [S_ADDR_W-1:0]   Address_S_a;
    logic [S_DATA_W-1:0]   Data_in_S_a;
    logic                  Write_en_S_a;
    logic [S_ADDR_W-1:0]   Address_S_b;
    logic [S_DATA_W-1:0]   Data_in_S_b;
    logic                  Write_en_S_b;
    logic                  busy;
    logic                  finish;

    modport master (
        input  start, plane, RA_init, CA_init, SRAM_read_data,
        output SRAM_address, SRAM_we_n,
        output Address_S_a, Data_in_S_a, Write_en_S_a,
        output Address_S_b, Data_in_S_b, Write_en_S_b,
        output busy, finish
    );

    modport slave (
        output start, plane, RA_init, CA_init, SRAM_read_data,
        input  SRAM_address, SRAM_we_n,
        input  Address_S_a, Data_in_S_a, Write_en_S_a,
        input  Address_S_b, Data_in_S_b, Write_en_S_b,
        input  busy, finish
    );

endinterface

// File: rtl/fetch_s_block_pipe.sv
// Delay line matching the SRAM read latency; carries a valid bit and request tag.
module sram_read_pipe
    import fetch_s_block_pkg::*;
#(
    parameter int unsigned LATENCY = 2
)(
    input  logic      clk,
    input  logic      rst,
    input  pipe_ent_t in_ent,
    output pipe_ent_t out_ent,
    output logic      pending
);

    pipe_ent_t stage [LATENCY];

    // Shift one entry per cycle; synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < LATENCY; s++) stage[s] <= '0;
        end else begin
            stage[0] <= in_ent;
            for (int unsigned s = 1; s < LATENCY; s++) stage[s] <= stage[s-1];
        end
    end

    assign out_ent = stage[LATENCY-1];

    // Entries still in flight behind the output stage
    always_comb begin
        pending = 1'b0;
        for (int unsigned s = 0; s + 1 < LATENCY; s++) pending = pending | stage[s].valid;
    end

endmodule

// File: rtl/fetch_s_block.sv
// Reads one 8x8 block from SRAM and unpacks it into S RAM, one pixel per word.
module fetch_s_block
    import fetch_s_block_pkg::*;
#(
    parameter int unsigned       SRAM_LATENCY = 2,
    parameter logic [ADDR_W-1:0] Y_BASE       = Y_BASE_DEF,
    parameter logic [ADDR_W-1:0] U_BASE       = U_BASE_DEF,
    parameter logic [ADDR_W-1:0] V_BASE       = V_BASE_DEF
)(
    input logic             Clock_50,
    input logic             Reset,
    fetch_s_block_if.master bus
);

    fetch_state_t      state, state_nx;
    logic [TAG_W-1:0]  i_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] sram_addr_q;
    logic              is_y_q;
    logic              busy_q;
    logic              finish_q;
    logic [ADDR_W-1:0] base_c;
    logic              is_y_c;
    logic [ADDR_W-1:0] blk_base_c;
    logic [ADDR_W-1:0] stride_c;
    pipe_ent_t         pipe_in_c;
    pipe_ent_t         pipe_out;
    logic              pipe_pending;

    // Block origin from the request inputs, used on the start cycle
    always_comb begin
        base_c = V_BASE;
        is_y_c = 1'b0;
        case (decode_plane(bus.plane))
            PLANE_Y: begin
                base_c = Y_BASE;
                is_y_c = 1'b1;
            end
            PLANE_U: base_c = U_BASE;
            default: base_c = V_BASE;
        endcase
        blk_base_c = base_c + row_offset(bus.RA_init, is_y_c) + ADDR_W'(bus.CA_init);
    end

    assign stride_c = is_y_q ? Y_WORDS : UV_WORDS;

    // State register
    always_ff @(posedge Clock_50) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_ISSUE;
            S_ISSUE: if (i_cnt == 5'd31) state_nx = S_DRAIN;
            S_DRAIN: if (!pipe_pending) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Address generation, counters and handshake outputs
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            i_cnt       <= '0;
            row_base    <= '0;
            sram_addr_q <= '0;
            is_y_q      <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            busy_q   <= (state_nx != S_IDLE);
            finish_q <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_y_q      <= is_y_c;
                        row_base    <= blk_base_c;
                        sram_addr_q <= blk_base_c;
                        i_cnt       <= '0;
                    end
                end
                S_ISSUE: begin
                    if (i_cnt != 5'd31) begin
                        i_cnt <= i_cnt + 5'd1;
                        if (i_cnt[1:0] == 2'd3) begin
                            row_base    <= row_base + stride_c;
                            sram_addr_q <= row_base + stride_c;
                        end else begin
                            sram_addr_q <= sram_addr_q + 18'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag each issued address with its word index
    always_comb begin
        pipe_in_c       = '0;
        pipe_in_c.valid = (state == S_ISSUE);
        pipe_in_c.tag   = i_cnt;
    end

    sram_read_pipe #(
        .LATENCY (SRAM_LATENCY)
    ) u_pipe (
        .clk     (Clock_50),
        .rst     (Reset),
        .in_ent  (pipe_in_c),
        .out_ent (pipe_out),
        .pending (pipe_pending)
    );

    // Split the returning word into the even/odd pixel writes
    always_comb begin
        bus.Address_S_a  = '0;
        bus.Data_in_S_a  = '0;
        bus.Write_en_S_a = 1'b0;
        bus.Address_S_b  = '0;
        bus.Data_in_S_b  = '0;
        bus.Write_en_S_b = 1'b0;
        if (pipe_out.valid) begin
            bus.Address_S_a  = {1'b0, pipe_out.tag, 1'b0};
            bus.Data_in_S_a  = {24'd0, bus.SRAM_read_data[15:8]};
            bus.Write_en_S_a = 1'b1;
            bus.Address_S_b  = {1'b0, pipe_out.tag, 1'b1};
            bus.Data_in_S_b  = {24'd0, bus.SRAM_read_data[7:0]};
            bus.Write_en_S_b = 1'b1;
        end
    end

    assign bus.SRAM_address = sram_addr_q;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.busy         = busy_q;
    assign bus.finish       = finish_q;

endmodule

// File: tb/tb_fetch_s_block.sv
// Bench for fetch_s_block: latency-2 and latency-3 builds driven side by side.
module tb_fetch_s_block;

    logic       Clock_50 = 1'b0;
    logic       Reset;
    logic       start;
    logic [1:0] plane;
    logic [9:0] RA_init;
    logic [9:0] CA_init;
    logic [15:0] salt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock_50 = ~Clock_50;

    fetch_s_block_if bus0();
    fetch_s_block_if bus1();

    fetch_s_block #(.SRAM_LATENCY(2)) dut0 (.Clock_50(Clock_50), .Reset(Reset), .bus(bus0));
    fetch_s_block #(.SRAM_LATENCY(3)) dut1 (.Clock_50(Clock_50), .Reset(Reset), .bus(bus1));

    assign bus0.start = start;   assign bus1.start = start;
    assign bus0.plane = plane;   assign bus1.plane = plane;
    assign bus0.RA_init = RA_init; assign bus1.RA_init = RA_init;
    assign bus0.CA_init = CA_init; assign bus1.CA_init = CA_init;

    // SRAM contents: dut0 sees a salted hash (word 0 fixed), dut1 an incrementing pattern
    function automatic logic [15:0] mem_word(input int d, input logic [17:0] a, input logic [15:0] s);
        if (d == 1) return a[15:0];
        if (a == 18'd0) return 16'hA1B2;
        return 16'((32'(a) * 32'd40503) ^ {16'd0, s});
    endfunction

    // SRAM read-latency models
    logic [17:0] ad0 [3];
    logic [17:0] ad1 [3];
    always @(posedge Clock_50) begin
        ad0[0] <= bus0.SRAM_address; ad0[1] <= ad0[0]; ad0[2] <= ad0[1];
        ad1[0] <= bus1.SRAM_address; ad1[1] <= ad1[0]; ad1[2] <= ad1[1];
    end
    assign bus0.SRAM_read_data = mem_word(0, ad0[1], salt);
    assign bus1.SRAM_read_data = mem_word(1, ad1[2], salt);

    typedef struct {
        logic [17:0] addr;
        logic        we_n, busy, fin, wea, web;
        logic [6:0]  aa, ab;
        logic [31:0] da, db;
    } mon_t;

    function automatic mon_t get_mon(input int d);
        mon_t m;
        if (d == 0) begin
            m.addr = bus0.SRAM_address; m.we_n = bus0.SRAM_we_n; m.busy = bus0.busy; m.fin = bus0.finish;
            m.wea = bus0.Write_en_S_a; m.web = bus0.Write_en_S_b;
            m.aa = bus0.Address_S_a; m.ab = bus0.Address_S_b; m.da = bus0.Data_in_S_a; m.db = bus0.Data_in_S_b;
        end else begin
            m.addr = bus1.SRAM_address; m.we_n = bus1.SRAM_we_n; m.busy = bus1.busy; m.fin = bus1.finish;
            m.wea = bus1.Write_en_S_a; m.web = bus1.Write_en_S_b;
            m.aa = bus1.Address_S_a; m.ab = bus1.Address_S_b; m.da = bus1.Data_in_S_a; m.db = bus1.Data_in_S_b;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: SRAM word address of pixel pair i of the requested block
    function automatic int exp_addr(input logic [1:0] pl, input int ra, input int ca, input int i);
        int base, stride;
        case (pl)
            2'd0:    begin base = 0;     stride = 160; end
            2'd1:    begin base = 38400; stride = 80;  end
            default: begin base = 57600; stride = 80;  end
        endcase
        return base + (ra + i / 4) * stride + ca + (i % 4);
    endfunction

    // One block request; optional ignored re-starts and optional reset at +10
    task automatic run_block(input logic [1:0] pl, input int ra, input int ca,
                             input bit pulses, input bit rst_mid, input int e_first, input int e_last);
        logic [31:0] s_mem [2][64];
        int na [2], nb [2], nfin [2], fin_j [2], last_wr [2], nlate [2];
        int lat [2];
        mon_t m;
        bit live;
        lat[0] = 2; lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            na[d] = 0; nb[d] = 0; nfin[d] = 0; fin_j[d] = -1; last_wr[d] = -1; nlate[d] = 0;
            for (int k = 0; k < 64; k++) s_mem[d][k] = 32'hDEADBEEF;
        end
        @(negedge Clock_50);
        start = 1'b1; plane = pl; RA_init = 10'(ra); CA_init = 10'(ca);
        for (int j = 1; j <= 45; j++) begin
            @(negedge Clock_50);
            start = 1'b0;
            plane = 2'($urandom); RA_init = 10'($urandom); CA_init = 10'($urandom);
            live = !(rst_mid && j > 10);
            for (int d = 0; d < 2; d++) begin
                m = get_mon(d);
                if (live && j <= 32)
                    chk($sformatf("addr d%0d i%0d", d, j - 1), 32'(m.addr), exp_addr(pl, ra, ca, j - 1));
                if (e_first >= 0 && j == 1)  chk($sformatf("first_addr d%0d", d), 32'(m.addr), e_first);
                if (e_last >= 0 && j == 32)  chk($sformatf("last_addr d%0d", d), 32'(m.addr), e_last);
                if (j == 1 && live)           chk($sformatf("busy_start d%0d", d), 32'(m.busy), 32'd1);
                if (j == 3)                   chk($sformatf("we_n d%0d", d), 32'(m.we_n), 32'd1);
                if (!rst_mid && j == 34 + lat[d]) chk($sformatf("busy_end d%0d", d), 32'(m.busy), 32'd0);
                if (rst_mid && j == 11) begin
                    chk($sformatf("rst_wea d%0d", d), 32'(m.wea), 32'd0);
                    chk($sformatf("rst_web d%0d", d), 32'(m.web), 32'd0);
                    chk($sformatf("rst_busy d%0d", d), 32'(m.busy), 32'd0);
                    chk($sformatf("rst_addr d%0d", d), 32'(m.addr), 32'd0);
                end
                if (m.wea) begin
                    if (live) begin s_mem[d][m.aa[5:0]] = m.da; na[d]++; last_wr[d] = j; end
                    else nlate[d]++;
                end
                if (m.web) begin
                    if (live) begin s_mem[d][m.ab[5:0]] = m.db; nb[d]++; end
                    else nlate[d]++;
                end
                if (m.fin) begin nfin[d]++; fin_j[d] = j; end
            end
            if (pulses && (j == 5 || j == 20)) start = 1'b1;
            if (rst_mid && j == 10) Reset = 1'b1;
            if (rst_mid && j == 11) Reset = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            if (rst_mid) begin
                chk($sformatf("rst_no_finish d%0d", d), 32'(nfin[d]), 32'd0);
                chk($sformatf("rst_no_writes d%0d", d), 32'(nlate[d]), 32'd0);
            end else begin
                chk($sformatf("finish_count d%0d", d), 32'(nfin[d]), 32'd1);
                chk($sformatf("finish_cycle d%0d", d), 32'(fin_j[d]), 32'(33 + lat[d]));
                chk($sformatf("last_write_cycle d%0d", d), 32'(last_wr[d]), 32'(32 + lat[d]));
                chk($sformatf("writes_a d%0d", d), 32'(na[d]), 32'd32);
                chk($sformatf("writes_b d%0d", d), 32'(nb[d]), 32'd32);
                for (int i = 0; i < 32; i++) begin
                    logic [15:0] w;
                    w = mem_word(d, 18'(exp_addr(pl, ra, ca, i)), salt);
                    chk($sformatf("S d%0d [%0d]", d, (i / 4) * 8 + 2 * (i % 4)),
                        s_mem[d][(i / 4) * 8 + 2 * (i % 4)], {24'd0, w[15:8]});
                    chk($sformatf("S d%0d [%0d]", d, (i / 4) * 8 + 2 * (i % 4) + 1),
                        s_mem[d][(i / 4) * 8 + 2 * (i % 4) + 1], {24'd0, w[7:0]});
                end
                if (pl == 2'd0 && ra == 0 && ca == 0 && d == 0) begin
                    chk("S0_even_pixel", s_mem[0][0], 32'h000000A1);
                    chk("S1_odd_pixel", s_mem[0][1], 32'h000000B2);
                end
            end
        end
    endtask

    typedef struct {
        logic [1:0] pl;
        int         ra;
        int         ca;
        int         first;
        int         last;
    } vec_t;

    vec_t tbl [6];

    initial begin
        mon_t m;
        logic [1:0] pl;
        Reset = 1'b1; start = 1'b0; plane = 2'd0; RA_init = '0; CA_init = '0; salt = 16'h0;
        repeat (3) @(negedge Clock_50);
        for (int d = 0; d < 2; d++) begin
            m = get_mon(d);
            chk($sformatf("reset_addr d%0d", d), 32'(m.addr), 32'd0);
            chk($sformatf("reset_busy d%0d", d), 32'(m.busy), 32'd0);
            chk($sformatf("reset_finish d%0d", d), 32'(m.fin), 32'd0);
            chk($sformatf("reset_we_n d%0d", d), 32'(m.we_n), 32'd1);
            chk($sformatf("reset_wen d%0d", d), 32'({m.wea, m.web}), 32'd0);
            chk($sformatf("reset_data d%0d", d), m.da | m.db, 32'd0);
        end
        Reset = 1'b0;

        tbl[0] = '{pl: 2'd0, ra: 0,   ca: 0,   first: 0,     last: 1123};
        tbl[1] = '{pl: 2'd1, ra: 8,   ca: 4,   first: 39044, last: 39607};
        tbl[2] = '{pl: 2'd3, ra: 232, ca: 76,  first: 76236, last: 76799};
        tbl[3] = '{pl: 2'd2, ra: 232, ca: 76,  first: 76236, last: 76799};
        tbl[4] = '{pl: 2'd0, ra: 232, ca: 156, first: 37276, last: 38399};
        tbl[5] = '{pl: 2'd1, ra: 0,   ca: 0,   first: 38400, last: 38963};
        for (int t = 0; t < 6; t++)
            run_block(tbl[t].pl, tbl[t].ra, tbl[t].ca, 1'b0, 1'b0, tbl[t].first, tbl[t].last);

        for (int t = 0; t < 8; t++) begin
            salt = 16'($urandom);
            pl = 2'($urandom_range(0, 3));
            run_block(pl, 8 * $urandom_range(0, 29), 4 * $urandom_range(0, (pl == 2'd0) ? 39 : 19),
                      1'($urandom_range(0, 1)), 1'b0, -1, -1);
        end

        run_block(2'd0, 16, 20, 1'b1, 1'b0, -1, -1);
        run_block(2'd1, 40, 8, 1'b0, 1'b1, -1, -1);
        run_block(2'd2, 0, 0, 1'b0, 1'b0, 57600, 58163);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
